// File: rtl/filter_test_sequencer.sv
// Scripted step controller for the filter bench: applies table entries to exp_sig_gen,
// measures the peak of every filter output over a fixed window and streams one record per filter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; table writable, test_* held at 0
// ST_SETTLE  | test_* driven from table[step]; wait SETTLE_CYCLES
// ST_MEASURE | DWELL_CYCLES samples, per-filter signed peak and position
// ST_REPORT  | one record per filter over valid/ready, then next step or IDLE
module filter_test_sequencer #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int NUM_FILTERS      = 4,
  parameter int NUM_STEPS        = 8,
  parameter int SETTLE_CYCLES    = 64,
  parameter int DWELL_CYCLES     = 1024,
  localparam int AW = $clog2(NUM_STEPS),
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int PW = $clog2(DWELL_CYCLES),
  localparam int W  = SIZE_FILTER_DATA
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [AW-1:0]               cfg_addr,
  input  logic [SIZE_DELAY+1:0]       cfg_data,
  input  logic                        start,
  input  logic [AW-1:0]               step_last,
  input  logic                        abort,
  input  logic [NUM_FILTERS*W-1:0]    filt_data,
  output logic                        test_overlay,
  output logic                        test_rate,
  output logic [SIZE_DELAY-1:0]       test_delay,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [AW-1:0]               res_step,
  output logic [FW-1:0]               res_filter,
  output logic [W-1:0]                res_peak,
  output logic [PW-1:0]               res_peak_pos,
  output logic                        done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  logic [1:0]            state;
  logic [AW-1:0]         step;
  logic [AW-1:0]         last_step;
  logic [CW-1:0]         settle_cnt;
  logic [PW-1:0]         sample_idx;
  logic signed [W-1:0]   peak     [NUM_FILTERS];
  logic [PW-1:0]         peak_pos [NUM_FILTERS];
  logic [SIZE_DELAY+1:0] step_table [NUM_STEPS];

  logic signed [W-1:0]   sample   [NUM_FILTERS];
  logic signed [W-1:0]   peak_nxt [NUM_FILTERS];
  logic [PW-1:0]         pos_nxt  [NUM_FILTERS];
  logic [SIZE_DELAY+1:0] start_entry;
  logic [SIZE_DELAY+1:0] next_entry;
  logic [FW-1:0]         fil_next;
  logic                  rec_accept;
  logic                  last_filter;

  // First sample of the window always loads, which is equivalent to starting from the most-negative value.
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      sample[f]   = $signed(filt_data[f*W +: W]);
      peak_nxt[f] = peak[f];
      pos_nxt[f]  = peak_pos[f];
      if ((sample_idx == '0) || (sample[f] > peak[f])) begin
        peak_nxt[f] = sample[f];
        pos_nxt[f]  = sample_idx;
      end
    end
  end

  // A write and a start in the same cycle: the new data reaches test_* directly.
  assign start_entry = (cfg_we && (cfg_addr == '0)) ? cfg_data : step_table[0];
  assign next_entry  = step_table[step + AW'(1)];
  assign fil_next    = res_filter + FW'(1);
  assign rec_accept  = res_valid & res_ready;
  assign last_filter = (res_filter == FW'(NUM_FILTERS - 1));

  always_ff @(posedge clk) begin
    if (!reset && !abort && (state == ST_IDLE) && cfg_we)
      step_table[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      step         <= '0;
      last_step    <= '0;
      settle_cnt   <= '0;
      sample_idx   <= '0;
      test_overlay <= 1'b0;
      test_rate    <= 1'b0;
      test_delay   <= '0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_step     <= '0;
      res_filter   <= '0;
      res_peak     <= '0;
      res_peak_pos <= '0;
      done         <= 1'b0;
      for (int f = 0; f < NUM_FILTERS; f++) begin
        peak[f]     <= '0;
        peak_pos[f] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= ST_IDLE;
        busy         <= 1'b0;
        res_valid    <= 1'b0;
        test_overlay <= 1'b0;
        test_rate    <= 1'b0;
        test_delay   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              last_step  <= step_last;
              step       <= '0;
              {test_overlay, test_rate, test_delay} <= start_entry;
              settle_cnt <= CW'(SETTLE_CYCLES - 1);
              busy       <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == '0) begin
              sample_idx <= '0;
              state      <= ST_MEASURE;
            end else begin
              settle_cnt <= settle_cnt - CW'(1);
            end
          end
          ST_MEASURE: begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
              peak[f]     <= peak_nxt[f];
              peak_pos[f] <= pos_nxt[f];
            end
            sample_idx <= sample_idx + PW'(1);
            if (sample_idx == '1) begin
              res_valid    <= 1'b1;
              res_step     <= step;
              res_filter   <= '0;
              res_peak     <= peak_nxt[0];
              res_peak_pos <= pos_nxt[0];
              state        <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            if (rec_accept) begin
              if (last_filter) begin
                res_valid <= 1'b0;
                if (step == last_step) begin
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  test_overlay <= 1'b0;
                  test_rate    <= 1'b0;
                  test_delay   <= '0;
                  state        <= ST_IDLE;
                end else begin
                  step       <= step + AW'(1);
                  {test_overlay, test_rate, test_delay} <= next_entry;
                  settle_cnt <= CW'(SETTLE_CYCLES - 1);
                  state      <= ST_SETTLE;
                end
              end else begin
                res_filter   <= fil_next;
                res_peak     <= peak[fil_next];
                res_peak_pos <= peak_pos[fil_next];
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
